uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; ports: sys_clk, sys_rst_l (sync active-low), tx_dataH/tx_validH/tx_readyH byte input, uart_xmitH serial out, tx_busyH, tx_doneH, fifo_countH
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_l,
  input  logic [7:0]  tx_dataH,
  input  logic        tx_validH,
  output logic        tx_readyH,
  output logic        uart_xmitH,
  output logic        tx_busyH,
  output logic        tx_doneH,
  output logic [AW:0] fifo_countH
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cell, w_cell_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic r_xmit, r_done, w_xmit_nxt, w_done_nxt, w_pop, w_wr, w_cell_last;
  assign w_cell_last = r_cell == CW'(CLKS_PER_BIT - 1);
  assign tx_readyH = r_count < (AW+1)'(DEPTH);
  assign w_wr = tx_validH && tx_readyH;
  assign uart_xmitH = r_xmit;
  assign tx_doneH = r_done;
  assign tx_busyH = r_state != IDLE;
  assign fifo_countH = r_count;
  always_comb begin
    w_state_nxt = r_state;
    w_cell_nxt = r_cell + 1'b1;
    w_bit_nxt = r_bit;
    w_shift_nxt = r_shift;
    w_pop = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cell_nxt = '0;
        w_bit_nxt = '0;
        if (r_count != 0) begin
          w_state_nxt = START;
          w_pop = 1'b1;
          w_shift_nxt = r_mem[r_rp];
        end
      end
      START: if (w_cell_last) begin
        w_state_nxt = DATA;
        w_cell_nxt = '0;
        w_bit_nxt = '0;
      end
      DATA: if (w_cell_last) begin
        w_cell_nxt = '0;
        w_shift_nxt = {1'b0, r_shift[7:1]};
        w_bit_nxt = r_bit + 1'b1;
        if (r_bit == 3'd7) w_state_nxt = STOP;
      end
      STOP: if (w_cell_last) begin
        w_cell_nxt = '0;
        w_bit_nxt = '0;
        w_done_nxt = 1'b1;
        w_state_nxt = IDLE;
        if (r_count != 0) begin
          w_state_nxt = START;
          w_pop = 1'b1;
          w_shift_nxt = r_mem[r_rp];
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cell_nxt = '0;
        w_bit_nxt = '0;
      end
    endcase
    w_xmit_nxt = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_shift_nxt[0] : 1'b1;
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      r_state <= IDLE;
      r_cell <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_xmit <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cell <= w_cell_nxt;
      r_bit <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_wp <= r_wp + AW'(w_wr);
      r_rp <= r_rp + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_xmit <= w_xmit_nxt;
      r_done <= w_done_nxt;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst_l && w_wr) r_mem[r_wp] <= tx_dataH;
  end
endmodule
